reg_bank: RTL and testbench

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits wide. Every selected register executes the same FunSel operation: increment, decrement, full load, clear, or one of four half-word loads. Two independent registered-data read ports feed the ALU/address datapath. This block replaces discrete per-register instances in the register-file level of the datapath.

---
 rtl/reg_bank_pkg.sv | 17 +
 rtl/reg_slice.sv | 71 +++++++
 rtl/reg_bank.sv | 52 +++++
 tb/tb_reg_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared FunSel encoding for the register bank and its per-register slices.
package reg_bank_pkg;

  localparam int FS_W = 3;

  typedef enum logic [FS_W-1:0] {
    FS_DEC       = 3'b000,
    FS_INC       = 3'b001,
    FS_LOAD      = 3'b010,
    FS_CLR       = 3'b011,
    FS_LDLO_Z    = 3'b100,
    FS_LDLO_KEEP = 3'b101,
    FS_LDHI_KEEP = 3'b110,
    FS_LDLO_SEXT = 3'b111
  } funsel_e;

endpackage

// File: rtl/reg_slice.sv
// One bank register: executes FunSel when E is high, result visible one cycle later; no backpressure.
// Optional sticky wrap flag under REG_BANK_WRAP_FLAG_EN.
module reg_slice
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [FS_W-1:0]  FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
`ifdef REG_BANK_WRAP_FLAG_EN
  ,
  output logic             Wrap
`endif
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (E) begin
      case (funsel_e'(FunSel))
        FS_DEC:       r_d = r_q - WIDTH'(1);
        FS_INC:       r_d = r_q + WIDTH'(1);
        FS_LOAD:      r_d = I;
        FS_CLR:       r_d = '0;
        FS_LDLO_Z:    r_d = {{H{1'b0}}, I[H-1:0]};
        FS_LDLO_KEEP: r_d = {r_q[WIDTH-1:H], I[H-1:0]};
        FS_LDHI_KEEP: r_d = {I[H-1:0], r_q[H-1:0]};
        FS_LDLO_SEXT: r_d = {{H{I[H-1]}}, I[H-1:0]};
        default:      r_d = r_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign Q = r_q;

`ifdef REG_BANK_WRAP_FLAG_EN
  logic wrap_q, wrap_d;

  // Inc/dec only ever set the flag; any load-class op clears it.
  always_comb begin
    wrap_d = wrap_q;
    if (E) begin
      case (funsel_e'(FunSel))
        FS_DEC:  if (r_q == '0) wrap_d = 1'b1;
        FS_INC:  if (r_q == '1) wrap_d = 1'b1;
        default: wrap_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign Wrap = wrap_q;
`endif

endmodule

// File: rtl/reg_bank.sv
// NUM_REGS x WIDTH register bank with two combinational read ports; 1-cycle write latency, no backpressure.
// REG_BANK_WRAP_FLAG_EN adds the sticky per-register Wrap output.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [FS_W-1:0]     FunSel,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB
`ifdef REG_BANK_WRAP_FLAG_EN
  ,
  output logic [NUM_REGS-1:0] Wrap
`endif
);

  localparam int NUM_IDX = 2 ** SEL_W;

  // Padded to the full select range so unused indices read back as zero.
  logic [WIDTH-1:0] q_all [NUM_IDX];

  for (genvar k = 0; k < NUM_IDX; k++) begin : g_reg
    if (k < NUM_REGS) begin : g_slice
      reg_slice #(.WIDTH(WIDTH)) u_slice (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (RegSel[k]),
        .FunSel (FunSel),
        .I      (I),
        .Q      (q_all[k])
`ifdef REG_BANK_WRAP_FLAG_EN
        ,
        .Wrap   (Wrap[k])
`endif
      );
    end else begin : g_pad
      assign q_all[k] = '0;
    end
  end

  assign OutA = q_all[OutASel];
  assign OutB = q_all[OutBSel];

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed vector table, corner sequences, random traffic vs. arithmetic model.
module tb_reg_bank;

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Default-sized instance
  logic        Reset1;
  logic [15:0] I1;
  logic [3:0]  RegSel1;
  logic [2:0]  FunSel1;
  logic [1:0]  ASel1, BSel1;
  logic [15:0] OutA1, OutB1;
  // WIDTH=8, NUM_REGS=3 instance
  logic        Reset2;
  logic [7:0]  I2;
  logic [2:0]  RegSel2;
  logic [2:0]  FunSel2;
  logic [1:0]  ASel2, BSel2;
  logic [7:0]  OutA2, OutB2;
`ifdef REG_BANK_WRAP_FLAG_EN
  logic [3:0]  Wrap1;
  logic [2:0]  Wrap2;
`endif

  reg_bank u_dut1 (
    .Clock(Clock), .Reset(Reset1), .I(I1), .RegSel(RegSel1), .FunSel(FunSel1),
    .OutASel(ASel1), .OutBSel(BSel1), .OutA(OutA1), .OutB(OutB1)
`ifdef REG_BANK_WRAP_FLAG_EN
    , .Wrap(Wrap1)
`endif
  );

  reg_bank #(.WIDTH(8), .NUM_REGS(3)) u_dut2 (
    .Clock(Clock), .Reset(Reset2), .I(I2), .RegSel(RegSel2), .FunSel(FunSel2),
    .OutASel(ASel2), .OutBSel(BSel2), .OutA(OutA2), .OutB(OutB2)
`ifdef REG_BANK_WRAP_FLAG_EN
    , .Wrap(Wrap2)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers, updated with modular arithmetic.
  int m1 [4];
  int w1 [4];
  int m2 [3];
  int w2 [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_next(input int v, input int fs, input int d, input int w);
    int m, hh, lo;
    m  = 1 << w;
    hh = 1 << (w / 2);
    lo = d % hh;
    case (fs)
      0: return (v + m - 1) % m;
      1: return (v + 1) % m;
      2: return d % m;
      3: return 0;
      4: return lo;
      5: return (v / hh) * hh + lo;
      6: return lo * hh + (v % hh);
      default: return (lo >= hh / 2) ? lo + m - hh : lo;
    endcase
  endfunction

  function automatic int model_wrap(input int v, input int fs, input int wold, input int w);
    if (fs >= 2) return 0;
    if (fs == 1 && v == (1 << w) - 1) return 1;
    if (fs == 0 && v == 0) return 1;
    return wold;
  endfunction

  task automatic step1(input logic [3:0] rs, input logic [2:0] fs, input logic [15:0] d,
                       input logic [1:0] as, input logic [1:0] bs);
    RegSel1 = rs; FunSel1 = fs; I1 = d; ASel1 = as; BSel1 = bs;
    @(posedge Clock);
    for (int k = 0; k < 4; k++)
      if (rs[k]) begin
        w1[k] = model_wrap(m1[k], int'(fs), w1[k], 16);
        m1[k] = model_next(m1[k], int'(fs), int'(d), 16);
      end
    #1;
  endtask

  task automatic step2(input logic [2:0] rs, input logic [2:0] fs, input logic [7:0] d,
                       input logic [1:0] as, input logic [1:0] bs);
    RegSel2 = rs; FunSel2 = fs; I2 = d; ASel2 = as; BSel2 = bs;
    @(posedge Clock);
    for (int k = 0; k < 3; k++)
      if (rs[k]) begin
        w2[k] = model_wrap(m2[k], int'(fs), w2[k], 8);
        m2[k] = model_next(m2[k], int'(fs), int'(d), 8);
      end
    #1;
  endtask

  function automatic int rd2(input int idx);
    return (idx < 3) ? m2[idx] : 0;
  endfunction

  function automatic logic [3:0] wvec1();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = w1[k][0];
    return r;
  endfunction

  function automatic logic [2:0] wvec2();
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = w2[k][0];
    return r;
  endfunction

  typedef struct {
    logic [3:0]  rs;
    logic [2:0]  fs;
    logic [15:0] d;
    logic [1:0]  as;
    logic [1:0]  bs;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [3:0]  exp_w;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{4'b0101, 3'b010, 16'h1234, 2'd0, 2'd2, 16'h1234, 16'h1234, 4'b0000};
    tbl[1]  = '{4'b0000, 3'b011, 16'h0000, 2'd1, 2'd3, 16'h0000, 16'h0000, 4'b0000};
    tbl[2]  = '{4'b0010, 3'b010, 16'hFFFF, 2'd1, 2'd0, 16'hFFFF, 16'h1234, 4'b0000};
    tbl[3]  = '{4'b0010, 3'b001, 16'h0000, 2'd1, 2'd2, 16'h0000, 16'h1234, 4'b0010};
    tbl[4]  = '{4'b0010, 3'b001, 16'h0000, 2'd1, 2'd1, 16'h0001, 16'h0001, 4'b0010};
    tbl[5]  = '{4'b0001, 3'b011, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'h0001, 4'b0010};
    tbl[6]  = '{4'b0001, 3'b000, 16'h0000, 2'd0, 2'd1, 16'hFFFF, 16'h0001, 4'b0011};
    tbl[7]  = '{4'b1000, 3'b010, 16'hABCD, 2'd3, 2'd0, 16'hABCD, 16'hFFFF, 4'b0011};
    tbl[8]  = '{4'b1000, 3'b101, 16'h0085, 2'd3, 2'd2, 16'hAB85, 16'h1234, 4'b0011};
    tbl[9]  = '{4'b1000, 3'b110, 16'h0085, 2'd3, 2'd2, 16'h8585, 16'h1234, 4'b0011};
    tbl[10] = '{4'b1000, 3'b111, 16'h0085, 2'd3, 2'd2, 16'hFF85, 16'h1234, 4'b0011};
    tbl[11] = '{4'b1000, 3'b100, 16'h0012, 2'd3, 2'd2, 16'h0012, 16'h1234, 4'b0011};
    tbl[12] = '{4'b0011, 3'b001, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'h0002, 4'b0011};
    tbl[13] = '{4'b0010, 3'b010, 16'h0007, 2'd1, 2'd3, 16'h0007, 16'h0012, 4'b0001};

    // ---- instance 1: reset state ----
    Reset1 = 1'b1; RegSel1 = 4'b1111; FunSel1 = 3'b010; I1 = 16'h5A5A; ASel1 = 0; BSel1 = 1;
    Reset2 = 1'b1; RegSel2 = 3'b000;  FunSel2 = 3'b000; I2 = 8'h00;     ASel2 = 0; BSel2 = 0;
    repeat (2) @(posedge Clock);
    #1;
    Reset1 = 1'b0; RegSel1 = '0;
    for (int k = 0; k < 4; k++) begin m1[k] = 0; w1[k] = 0; end
    chk("rst_a0", OutA1, 16'h0);
    chk("rst_b1", OutB1, 16'h0);
    ASel1 = 2; BSel1 = 3; #1;
    chk("rst_a2", OutA1, 16'h0);
    chk("rst_b3", OutB1, 16'h0);
`ifdef REG_BANK_WRAP_FLAG_EN
    chk("rst_wrap", Wrap1, 4'b0);
`endif

    // ---- directed table ----
    for (int v = 0; v < 14; v++) begin
      step1(tbl[v].rs, tbl[v].fs, tbl[v].d, tbl[v].as, tbl[v].bs);
      chk($sformatf("tbl%0d_a", v), OutA1, tbl[v].exp_a);
      chk($sformatf("tbl%0d_b", v), OutB1, tbl[v].exp_b);
`ifdef REG_BANK_WRAP_FLAG_EN
      chk($sformatf("tbl%0d_wrap", v), Wrap1, tbl[v].exp_w);
`endif
    end

    // ---- same-cycle read returns old value ----
    RegSel1 = 4'b0100; FunSel1 = 3'b010; I1 = 16'h5555; ASel1 = 2; BSel1 = 2;
    #2;
    chk("wt_old", OutA1, 16'h1234);
    step1(4'b0100, 3'b010, 16'h5555, 2'd2, 2'd2);
    chk("wt_new", OutA1, 16'h5555);

    // ---- reset overrides a concurrent inc on all registers ----
    Reset1 = 1'b1; RegSel1 = 4'b1111; FunSel1 = 3'b001;
    @(posedge Clock); #1;
    Reset1 = 1'b0; RegSel1 = '0;
    for (int k = 0; k < 4; k++) begin m1[k] = 0; w1[k] = 0; end
    ASel1 = 0; BSel1 = 1; #1;
    chk("rstinc_r0", OutA1, 16'h0);
    chk("rstinc_r1", OutB1, 16'h0);
    ASel1 = 2; BSel1 = 3; #1;
    chk("rstinc_r2", OutA1, 16'h0);
    chk("rstinc_r3", OutB1, 16'h0);
`ifdef REG_BANK_WRAP_FLAG_EN
    chk("rstinc_wrap", Wrap1, 4'b0);
`endif

    // ---- random traffic vs model ----
    for (int n = 0; n < 300; n++) begin
      logic [15:0] d;
      d = (n % 7 == 0) ? 16'hFFFF : 16'($urandom);
      step1(4'($urandom), 3'($urandom), d, 2'($urandom), 2'($urandom));
      chk("rnd_a", OutA1, 32'(m1[ASel1]));
      chk("rnd_b", OutB1, 32'(m1[BSel1]));
`ifdef REG_BANK_WRAP_FLAG_EN
      chk("rnd_wrap", Wrap1, wvec1());
`endif
    end

    // ---- instance 2: WIDTH=8, NUM_REGS=3 ----
    Reset2 = 1'b0;
    for (int k = 0; k < 3; k++) begin m2[k] = 0; w2[k] = 0; end
    step2(3'b001, 3'b010, 8'hFF, 2'd0, 2'd1);
    chk("w8_load", OutA2, 8'hFF);
    step2(3'b001, 3'b001, 8'h00, 2'd0, 2'd3);
    chk("w8_inc_wrap", OutA2, 8'h00);
    chk("w8_sel3_b", OutB2, 8'h00);
`ifdef REG_BANK_WRAP_FLAG_EN
    chk("w8_wrapflag", Wrap2, 3'b001);
`endif
    step2(3'b110, 3'b010, 8'h5A, 2'd1, 2'd2);
    chk("w8_r1", OutA2, 8'h5A);
    chk("w8_r2", OutB2, 8'h5A);
    ASel2 = 3; #1;
    chk("w8_sel3_a", OutA2, 8'h00);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] d;
      d = (n % 5 == 0) ? 8'hFF : 8'($urandom);
      step2(3'($urandom), 3'($urandom), d, 2'($urandom), 2'($urandom));
      chk("w8_rnd_a", OutA2, 32'(rd2(int'(ASel2))));
      chk("w8_rnd_b", OutB2, 32'(rd2(int'(BSel2))));
`ifdef REG_BANK_WRAP_FLAG_EN
      chk("w8_rnd_wrap", Wrap2, wvec2());
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
